video_src_switch: RTL and testbench

Frame-aligned AXI4-Stream 2:1 source switch and test-pattern sequencer for the video_ctrl pipeline. It selects between the camera stream (source 0) and the test-pattern generator stream (source 1), forwards the selected one to the downstream video path, and changes source only on frame boundaries. It drives the test-pattern generator's enable and configuration inputs so the generator is started, stopped and reconfigured only at frame boundaries.

---
 rtl/video_src_switch.sv | 216 +++++++++++++++++++++
 tb/tb_video_src_switch.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_src_switch.sv
// Frame-aligned 2:1 AXI4-Stream source switch (camera / test pattern) that also
// sequences the test-pattern generator so it only starts, stops or reconfigures on SOF.
//
// state | meaning
// IDLE  | stopped; both sources stalled, generator off
// START | load generator config (if test pattern selected), enable it
// SYNC  | discard beats of the active source until its SOF is presented
// PASS  | combinational forward of the active source to m
// STOP  | boundary reached; generator off, pick new source
// GAP   | generator held off for TP_OFF_CYCLES before restarting
module video_src_switch #(
  parameter int DW            = 8,
  parameter int TP_OFF_CYCLES = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          sel_i,
  input  logic [1:0]    tp_type_i,
  input  logic [10:0]   tp_width_i,
  input  logic [10:0]   tp_height_i,
  input  logic          tp_cfg_upd_i,
  output logic          tp_enable_o,
  output logic [1:0]    tp_type_o,
  output logic [10:0]   tp_width_o,
  output logic [10:0]   tp_height_o,
  input  logic [DW-1:0] s0_tdata,
  input  logic          s0_tvalid,
  input  logic          s0_tuser,
  input  logic          s0_tlast,
  output logic          s0_tready,
  input  logic [DW-1:0] s1_tdata,
  input  logic          s1_tvalid,
  input  logic          s1_tuser,
  input  logic          s1_tlast,
  output logic          s1_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tuser,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic          active_sel_o,
  output logic [2:0]    state_o,
  output logic [15:0]   frame_cnt_o,
  output logic [15:0]   drop_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SYNC  = 3'd2,
    ST_PASS  = 3'd3,
    ST_STOP  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  localparam int GW = (TP_OFF_CYCLES > 1) ? $clog2(TP_OFF_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(TP_OFF_CYCLES - 1);

  state_t        state_q, state_d;
  logic          active_sel_q, active_sel_d;
  logic          tp_enable_q, tp_enable_d;
  logic [1:0]    tp_type_q, tp_type_d;
  logic [10:0]   tp_width_q, tp_width_d;
  logic [10:0]   tp_height_q, tp_height_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          cfg_pend_q, cfg_pend_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic [DW-1:0] act_tdata;
  logic          act_tvalid;
  logic          act_tuser;
  logic          act_tlast;
  logic          act_sof;
  logic          act_ready;
  logic          cfg_upd_act;
  logic          bnd_req;

  assign act_tdata   = active_sel_q ? s1_tdata  : s0_tdata;
  assign act_tvalid  = active_sel_q ? s1_tvalid : s0_tvalid;
  assign act_tuser   = active_sel_q ? s1_tuser  : s0_tuser;
  assign act_tlast   = active_sel_q ? s1_tlast  : s0_tlast;
  assign act_sof     = act_tvalid & act_tuser;
  assign cfg_upd_act = tp_cfg_upd_i & active_sel_q;

  // Same-cycle config pulse counts, so a pulse coinciding with an SOF is not deferred a frame.
  assign bnd_req = (sel_i != active_sel_q) | ~enable_i | cfg_pend_q | cfg_upd_act;

  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    tp_enable_d  = tp_enable_q;
    tp_type_d    = tp_type_q;
    tp_width_d   = tp_width_q;
    tp_height_d  = tp_height_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    cfg_pend_d   = cfg_pend_q;
    gap_cnt_d    = gap_cnt_q;
    act_ready    = 1'b0;
    m_tdata      = '0;
    m_tvalid     = 1'b0;
    m_tuser      = 1'b0;
    m_tlast      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tp_enable_d = 1'b0;
        cfg_pend_d  = 1'b0;
        if (enable_i) begin
          active_sel_d = sel_i;
          state_d      = ST_START;
        end
      end

      ST_START: begin
        if (active_sel_q) begin
          tp_type_d   = tp_type_i;
          tp_width_d  = tp_width_i;
          tp_height_d = tp_height_i;
          tp_enable_d = 1'b1;
        end else begin
          tp_enable_d = 1'b0;
        end
        state_d = ST_SYNC;
      end

      ST_SYNC: begin
        if (cfg_upd_act) cfg_pend_d = 1'b1;
        if (!enable_i) begin
          tp_enable_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (act_sof) begin
          state_d = ST_PASS;
        end else begin
          act_ready = 1'b1;
          if (act_tvalid && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end

      ST_PASS: begin
        if (cfg_upd_act) cfg_pend_d = 1'b1;
        if (act_sof && bnd_req) begin
          tp_enable_d = 1'b0;
          state_d     = ST_STOP;
        end else begin
          m_tdata   = act_tdata;
          m_tvalid  = act_tvalid;
          m_tuser   = act_tuser;
          m_tlast   = act_tlast;
          act_ready = m_tready;
          if (act_sof && m_tready) frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end

      ST_STOP: begin
        tp_enable_d = 1'b0;
        cfg_pend_d  = 1'b0;
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else begin
          active_sel_d = sel_i;
          gap_cnt_d    = GAP_LOAD;
          state_d      = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_START;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    s0_tready = act_ready & ~active_sel_q;
    s1_tready = act_ready &  active_sel_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      active_sel_q <= 1'b0;
      tp_enable_q  <= 1'b0;
      tp_type_q    <= '0;
      tp_width_q   <= '0;
      tp_height_q  <= '0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      cfg_pend_q   <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      tp_enable_q  <= tp_enable_d;
      tp_type_q    <= tp_type_d;
      tp_width_q   <= tp_width_d;
      tp_height_q  <= tp_height_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      cfg_pend_q   <= cfg_pend_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign tp_enable_o  = tp_enable_q;
  assign tp_type_o    = tp_type_q;
  assign tp_width_o   = tp_width_q;
  assign tp_height_o  = tp_height_q;
  assign active_sel_o = active_sel_q;
  assign state_o      = state_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_video_src_switch.sv
// Bench for video_src_switch: frame-structured random sources, a per-cycle
// reference model of the switching rules, and directed scenarios with literal expectations.
module tb_video_src_switch;
  localparam int DW    = 8;
  localparam int TPOFF = 4;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int FRAME = W * H;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b0;
  logic          sel_i = 1'b0;
  logic [1:0]    tp_type_i = '0;
  logic [10:0]   tp_width_i = '0;
  logic [10:0]   tp_height_i = '0;
  logic          tp_cfg_upd_i = 1'b0;
  logic          tp_enable_o;
  logic [1:0]    tp_type_o;
  logic [10:0]   tp_width_o;
  logic [10:0]   tp_height_o;
  logic [DW-1:0] s0_tdata = '0;
  logic          s0_tvalid = 1'b0, s0_tuser = 1'b0, s0_tlast = 1'b0, s0_tready;
  logic [DW-1:0] s1_tdata = '0;
  logic          s1_tvalid = 1'b0, s1_tuser = 1'b0, s1_tlast = 1'b0, s1_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tuser, m_tlast;
  logic          m_tready = 1'b1;
  logic          active_sel_o;
  logic [2:0]    state_o;
  logic [15:0]   frame_cnt_o, drop_cnt_o;

  video_src_switch #(.DW(DW), .TP_OFF_CYCLES(TPOFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .sel_i(sel_i),
    .tp_type_i(tp_type_i), .tp_width_i(tp_width_i), .tp_height_i(tp_height_i),
    .tp_cfg_upd_i(tp_cfg_upd_i),
    .tp_enable_o(tp_enable_o), .tp_type_o(tp_type_o), .tp_width_o(tp_width_o),
    .tp_height_o(tp_height_o),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .active_sel_o(active_sel_o), .state_o(state_o),
    .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source generators: frames of W x H beats, data is a running beat counter.
  int src_idx[2] = '{0, 0};
  int src_cnt[2] = '{0, 0};
  bit src_vld[2] = '{1, 1};
  bit src_gaps[2] = '{0, 0};
  bit fire[2] = '{0, 0};
  int rdy_mode = 0;
  int pat_i = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int m_fire_cnt = 0;
  int s0_fire_cnt = 0;

  task automatic drive_src();
    s0_tdata  = DW'(src_cnt[0]);
    s0_tuser  = (src_idx[0] == 0);
    s0_tlast  = ((src_idx[0] % W) == W - 1);
    s0_tvalid = src_vld[0];
    s1_tdata  = DW'(src_cnt[1] + 128);
    s1_tuser  = (src_idx[1] == 0);
    s1_tlast  = ((src_idx[1] % W) == W - 1);
    s1_tvalid = src_vld[1];
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    tp_cfg_upd_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (fire[k]) begin
        src_idx[k] = (src_idx[k] + 1) % FRAME;
        src_cnt[k]++;
        src_vld[k] = src_gaps[k] ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else if (!src_vld[k]) begin
        src_vld[k] = src_gaps[k] ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
    drive_src();
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(0, 3) != 0);
      default: begin m_tready = pat[pat_i % 4]; pat_i++; end
    endcase
  endtask

  task automatic wait_state(input int s, input int max_cyc);
    for (int i = 0; i < max_cyc && state_o != 3'(s); i++) tick();
  endtask

  // Reference model of the switching rules (state numbering as exposed on state_o).
  int ms = 0, msel = 0, mtpen = 0, mtype = 0, mw = 0, mh = 0;
  int mfc = 0, mdc = 0, mpend = 0, mgap = 0;
  bit cv, cu, cl, csof, creq, cev, cer;
  logic [DW-1:0] cd;

  always @(negedge clk_i) begin
    cv = msel ? s1_tvalid : s0_tvalid;
    cu = msel ? s1_tuser  : s0_tuser;
    cl = msel ? s1_tlast  : s0_tlast;
    cd = msel ? s1_tdata  : s0_tdata;
    csof = cv && cu;
    creq = (int'(sel_i) != msel) || !enable_i || (mpend != 0) || (tp_cfg_upd_i && msel != 0);
    cev = 1'b0;
    cer = 1'b0;
    if (ms == 2 && enable_i) cer = !csof;
    if (ms == 3 && !(csof && creq)) begin
      cev = cv;
      cer = m_tready;
    end
    chk("m_tvalid", m_tvalid, cev);
    chk("s0_tready", s0_tready, cer && msel == 0);
    chk("s1_tready", s1_tready, cer && msel == 1);
    if (cev) begin
      chk("m_tdata", m_tdata, cd);
      chk("m_tuser", m_tuser, cu);
      chk("m_tlast", m_tlast, cl);
    end
    chk("state_o", state_o, ms);
    chk("active_sel_o", active_sel_o, msel);
    chk("tp_enable_o", tp_enable_o, mtpen);
    chk("tp_type_o", tp_type_o, mtype);
    chk("tp_width_o", tp_width_o, mw);
    chk("tp_height_o", tp_height_o, mh);
    chk("frame_cnt_o", frame_cnt_o, mfc);
    chk("drop_cnt_o", drop_cnt_o, mdc);

    fire[0] = s0_tvalid && s0_tready;
    fire[1] = s1_tvalid && s1_tready;
    if (m_tvalid && m_tready) m_fire_cnt++;
    if (fire[0]) s0_fire_cnt++;

    if (rst_i) begin
      ms = 0; msel = 0; mtpen = 0; mtype = 0; mw = 0; mh = 0;
      mfc = 0; mdc = 0; mpend = 0; mgap = 0;
    end else begin
      case (ms)
        0: begin
          mtpen = 0;
          mpend = 0;
          if (enable_i) begin msel = sel_i; ms = 1; end
        end
        1: begin
          if (msel != 0) begin
            mtpen = 1; mtype = tp_type_i; mw = tp_width_i; mh = tp_height_i;
          end
          ms = 2;
        end
        2: begin
          if (tp_cfg_upd_i && msel != 0) mpend = 1;
          if (!enable_i) begin
            mtpen = 0; ms = 0;
          end else begin
            if (cv && !cu && mdc < 65535) mdc++;
            if (csof) ms = 3;
          end
        end
        3: begin
          if (tp_cfg_upd_i && msel != 0) mpend = 1;
          if (csof && creq) begin
            mtpen = 0; ms = 4;
          end else if (csof && m_tready) begin
            mfc = (mfc + 1) % 65536;
          end
        end
        4: begin
          mtpen = 0;
          mpend = 0;
          if (!enable_i) ms = 0;
          else begin msel = sel_i; mgap = TPOFF; ms = 5; end
        end
        default: begin
          mgap--;
          if (mgap == 0) ms = 1;
        end
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int low;
  int snap_m, snap_s0;

  initial begin
    drive_src();
    tick();
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_state", state_o, 0);
    chk("rst_tp_enable", tp_enable_o, 0);
    chk("rst_frame_cnt", frame_cnt_o, 0);
    chk("rst_s0_tready", s0_tready, 0);

    // Mid-frame start on camera: beats 5..7 of the frame are discarded.
    tick();
    src_idx[0] = 5;
    drive_src();
    sel_i    = 1'b0;
    enable_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("start_state", state_o, 1);
    tick();
    @(negedge clk_i);
    chk("sync_state", state_o, 2);
    for (int i = 0; i < 100 && frame_cnt_o != 16'd3; i++) tick();
    chk("cam_frames", frame_cnt_o, 3);
    chk("cam_drops", drop_cnt_o, 3);
    chk("cam_tp_enable", tp_enable_o, 0);

    // Switch camera -> test pattern mid-frame.
    tp_type_i   = 2'd2;
    tp_width_i  = 11'd20;
    tp_height_i = 11'd10;
    sel_i       = 1'b1;
    wait_state(4, 50);
    chk("sw_stop_reached", state_o, 4);
    low = 0;
    while (tp_enable_o == 1'b0 && low < 50) begin tick(); low++; end
    chk("sw_tp_off_cycles", low, 6);
    chk("sw_tp_width", tp_width_o, 20);
    chk("sw_tp_height", tp_height_o, 10);
    chk("sw_active_sel", active_sel_o, 1);

    // Config update while on the test pattern.
    wait_state(3, 20);
    tick(); tick(); tick();
    tp_width_i   = 11'd16;
    tp_cfg_upd_i = 1'b1;
    tick();
    for (int i = 0; i < 50 && tp_enable_o == 1'b1; i++) tick();
    low = 0;
    while (tp_enable_o == 1'b0 && low < 50) begin tick(); low++; end
    chk("cfg_tp_off_cycles", low, 6);
    chk("cfg_tp_width", tp_width_o, 16);

    // Back to camera, then backpressure pattern 1,0,0,1.
    sel_i = 1'b0;
    for (int i = 0; i < 100 && !(active_sel_o == 1'b0 && state_o == 3'd3); i++) tick();
    chk("bp_on_camera", active_sel_o, 0);
    rdy_mode = 2;
    snap_m   = m_fire_cnt;
    snap_s0  = s0_fire_cnt;
    repeat (60) tick();
    chk("bp_no_loss", m_fire_cnt - snap_m, s0_fire_cnt - snap_s0);

    // Randomized operation.
    src_gaps = '{1, 1};
    rdy_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_i = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 199) == 0) sel_i = ~sel_i;
      if (enable_i) begin
        if ($urandom_range(0, 399) == 0) enable_i = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        enable_i = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) begin
        tp_type_i    = 2'($urandom_range(0, 3));
        tp_width_i   = 11'($urandom_range(1, 2047));
        tp_height_i  = 11'($urandom_range(1, 2047));
        tp_cfg_upd_i = 1'b1;
      end
    end

    // Disable mid-frame, then reset mid-frame.
    tick();
    rst_i    = 1'b0;
    src_gaps = '{0, 0};
    rdy_mode = 0;
    sel_i    = 1'b0;
    enable_i = 1'b1;
    wait_state(3, 300);
    chk("dis_in_pass", state_o, 3);
    tick();
    enable_i = 1'b0;
    wait_state(0, 100);
    @(negedge clk_i);
    chk("dis_idle", state_o, 0);
    chk("dis_m_tvalid", m_tvalid, 0);
    tick();
    enable_i = 1'b1;
    wait_state(3, 100);
    tick(); tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("mrst_state", state_o, 0);
    chk("mrst_frame_cnt", frame_cnt_o, 0);
    chk("mrst_drop_cnt", drop_cnt_o, 0);
    chk("mrst_m_tvalid", m_tvalid, 0);
    chk("mrst_s0_tready", s0_tready, 0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
